mem_bus_unit: RTL

//  Memory access sequencer directly downstream of the instruction decoder's o_mem_rd/o_mem_wr strobes.

---
 rtl/common_pkg.sv | 16 +
 rtl/mb_wait_timer.sv | 43 ++++
 rtl/mem_bus_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared types and widths for the memory bus sequencer slice.
package common_pkg;

    typedef enum logic [2:0] {
        MB_IDLE    = 3'd0,
        MB_SETUP   = 3'd1,
        MB_ACCESS  = 3'd2,
        MB_DONE    = 3'd3,
        MB_ABORT   = 3'd4,
        MB_RELEASE = 3'd5
    } mem_state_e;

    localparam int MB_ADDR_W = 16;
    localparam int MB_DATA_W = 16;

endpackage

// File: rtl/mb_wait_timer.sv
// Wait-state and timeout counters for one bus access; loaded in SETUP, stepped in ACCESS.
module mb_wait_timer #(
    parameter int WAIT_CYCLES = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_step,
    output logic o_wait_zero,
    output logic o_tmo_last
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] tmo_cnt;

    // Both counters saturate: wait stops at zero, timeout stops at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (!i_rst_n) begin
            wait_cnt <= '0;
            tmo_cnt  <= '0;
        end else if (i_load) begin
            wait_cnt <= WAIT_INIT;
            tmo_cnt  <= '0;
        end else if (i_step) begin
            if (wait_cnt != '0)
                wait_cnt <= wait_cnt - CNT_ONE;
            if (tmo_cnt != CNT_MAX)
                tmo_cnt <= tmo_cnt + CNT_ONE;
        end
    end

    assign o_wait_zero = (wait_cnt == '0);
    assign o_tmo_last  = (tmo_cnt == TMO_LAST);

endmodule

// File: rtl/mem_bus_unit.sv
// Turns single-cycle decoder read/write strobes into four-phase req/ack bus cycles
// with minimum wait states, timeout abort and read-data return.
module mem_bus_unit
    import common_pkg::*;
#(
    parameter int ADDR_W      = MB_ADDR_W,
    parameter int DATA_W      = MB_DATA_W,
    parameter int WAIT_CYCLES = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_rd,
    input  logic              i_mem_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic [DATA_W-1:0] i_bus_rdata
);

    mem_state_e state;
    mem_state_e next_state;

    logic req_one;
    logic req_both;
    logic wait_zero;
    logic tmo_last;
    logic ack_ok;
    logic coll_err;
    logic bus_we_q;

    assign req_one  = i_mem_rd ^ i_mem_wr;
    assign req_both = i_mem_rd & i_mem_wr;
    assign ack_ok   = (state == MB_ACCESS) && i_bus_ack && wait_zero;

    mb_wait_timer #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) u_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (state == MB_SETUP),
        .i_step      (state == MB_ACCESS),
        .o_wait_zero (wait_zero),
        .o_tmo_last  (tmo_last)
    );

    always_comb begin
        // NOTE: default assignment first so no branch leaves next_state unassigned (no latch).
        next_state = state;
        unique case (state)
            MB_IDLE:    if (req_one) next_state = MB_SETUP;
            MB_SETUP:   next_state = MB_ACCESS;
            // An accepted ack takes priority over a timeout on the same edge.
            MB_ACCESS: begin
                if (ack_ok)        next_state = MB_DONE;
                else if (tmo_last) next_state = MB_ABORT;
            end
            MB_DONE,
            MB_ABORT:   next_state = i_bus_ack ? MB_RELEASE : MB_IDLE;
            MB_RELEASE: if (!i_bus_ack) next_state = MB_IDLE;
            default:    next_state = MB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= MB_IDLE;
        else          state <= next_state;
    end

    // Address/direction/data only change when a request is accepted, so the bus never glitches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            bus_we_q    <= 1'b0;
        end else if (state == MB_IDLE && req_one) begin
            o_bus_addr <= i_addr;
            bus_we_q   <= i_mem_wr;
            if (i_mem_wr)
                o_bus_wdata <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata  <= '0;
            coll_err <= 1'b0;
        end else begin
            coll_err <= (state == MB_IDLE) && req_both;
            if (ack_ok && !bus_we_q)
                o_rdata <= i_bus_rdata;
        end
    end

    assign o_bus_we  = bus_we_q;
    assign o_busy    = (state == MB_SETUP) || (state == MB_ACCESS);
    assign o_bus_req = (state == MB_ACCESS);
    assign o_done    = (state == MB_DONE);
    assign o_err     = (state == MB_ABORT) || coll_err;

endmodule
